// File: rtl/serial_deser.sv
// Parametrised serial-to-parallel deserializer with a valid/ready holding register.
// Optional even-parity frame bit enabled by defining DESER_PARITY_EN.
module serial_deser #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    input  logic               si,
    output logic [WIDTH-1:0]   out,
    output logic               co,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               overrun,
    output logic [COUNT_W-1:0] word_count,
    output logic               parity_err
);

`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   data_q;
    logic [COUNT_W-1:0] count_q;
    logic               overrun_q, overrun_d;
    logic               data_bit;
    logic               load;

`ifdef DESER_PARITY_EN
    // The parity bit occupies the last frame slot and never enters the shift register.
    assign data_bit = (cnt_q != LAST);
`else
    assign data_bit = 1'b1;
`endif

    assign co = en && (cnt_q == LAST);

    always_comb begin
        out_d = out_q;
        if (en && data_bit) begin
            if (MSB_FIRST != 0) out_d = {out_q[WIDTH-2:0], si};
            else                out_d = {si, out_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        if (clear) begin
            state_d   = StEmpty;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (co) begin
                        load    = 1'b1;
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (co) begin
                        if (data_ready) load = 1'b1;
                        else            overrun_d = 1'b1;
                    end else if (data_ready) begin
                        state_d = StEmpty;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StEmpty;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            out_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            if (en) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
            out_q <= out_d;
            if (co)   count_q <= count_q + COUNT_W'(1);
            // Candidate is the post-shift word; on a parity slot out_d equals out_q.
            if (load) data_q <= out_d;
        end
    end

`ifdef DESER_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       perr_q <= 1'b0;
        else if (clear) perr_q <= 1'b0;
        else if (load)  perr_q <= (^out_q) ^ si;
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign out        = out_q;
    assign data_out   = data_q;
    assign data_valid = (state_q == StFull);
    assign overrun    = overrun_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: LSB- and MSB-first instances share stimulus and are
// checked against a bit-history reference model.
module tb_serial_deser;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef DESER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic rst, clear, en, si, data_ready;
    logic [W-1:0]  out0, out1, dout0, dout1;
    logic          co0, co1, dv0, dv1, ov0, ov1, pe0, pe1;
    logic [CW-1:0] wc0, wc1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the last W data bits received (bit 0 = newest) plus output-stage view.
    logic [W-1:0] m_hist;
    logic [W-1:0] m_d0, m_d1;
    int           m_total;
    int           m_count;
    bit           m_valid, m_ovr, m_perr;

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(W), .MSB_FIRST(0), .COUNT_W(CW)) dut_lsb (
        .clk(clk), .rst(rst), .clear(clear), .en(en), .si(si), .out(out0), .co(co0),
        .data_out(dout0), .data_valid(dv0), .data_ready(data_ready), .overrun(ov0),
        .word_count(wc0), .parity_err(pe0)
    );

    serial_deser #(.WIDTH(W), .MSB_FIRST(1), .COUNT_W(CW)) dut_msb (
        .clk(clk), .rst(rst), .clear(clear), .en(en), .si(si), .out(out1), .co(co1),
        .data_out(dout1), .data_valid(dv1), .data_ready(data_ready), .overrun(ov1),
        .word_count(wc1), .parity_err(pe1)
    );

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_lsb"}, 32'(out0), 32'(rev(m_hist)));
        check({tag, ".out_msb"}, 32'(out1), 32'(m_hist));
        check({tag, ".dout_lsb"}, 32'(dout0), 32'(m_d0));
        check({tag, ".dout_msb"}, 32'(dout1), 32'(m_d1));
        check({tag, ".valid_lsb"}, 32'(dv0), 32'(m_valid));
        check({tag, ".valid_msb"}, 32'(dv1), 32'(m_valid));
        check({tag, ".ovr_lsb"}, 32'(ov0), 32'(m_ovr));
        check({tag, ".ovr_msb"}, 32'(ov1), 32'(m_ovr));
        check({tag, ".wc_lsb"}, 32'(wc0), 32'(m_count));
        check({tag, ".wc_msb"}, 32'(wc1), 32'(m_count));
        check({tag, ".perr_lsb"}, 32'(pe0), 32'(m_perr));
        check({tag, ".perr_msb"}, 32'(pe1), 32'(m_perr));
    endtask

    task automatic model_edge(input bit e, input bit s, input bit r, input bit c);
        bit done;
        if (c) begin
            m_total = 0;
            m_hist  = '0;
            m_valid = 0;
            m_ovr   = 0;
            m_perr  = 0;
        end else begin
            done = 0;
            if (e) begin
                if ((m_total % FRAME) < W) m_hist = {m_hist[W-2:0], s};
                done = ((m_total % FRAME) == FRAME - 1);
                m_total++;
            end
            if (done) begin
                m_count = (m_count + 1) % (1 << CW);
                if (!m_valid || r) begin
                    m_valid = 1;
                    m_d0    = rev(m_hist);
                    m_d1    = m_hist;
                    m_perr  = (FRAME > W) ? ((^m_hist) ^ s) : 1'b0;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && r) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick(input bit e, input bit s, input bit r, input bit c);
        bit exp_co;
        en = e; si = s; data_ready = r; clear = c;
        #1;
        exp_co = e && ((m_total % FRAME) == FRAME - 1);
        check("co_lsb", 32'(co0), 32'(exp_co));
        check("co_msb", 32'(co1), 32'(exp_co));
        @(posedge clk);
        model_edge(e, s, r, c);
        #1;
        check_all("tick");
    endtask

    // Asserted between edges and checked before the next edge, so only an async reset passes.
    task automatic do_reset();
        rst = 1'b1;
        #3;
        m_hist = '0; m_d0 = '0; m_d1 = '0; m_total = 0; m_count = 0;
        m_valid = 0; m_ovr = 0; m_perr = 0;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit pbit, input bit rdy_last);
        for (int i = 0; i < W; i++) tick(1'b1, w[i], (i == W - 1 && FRAME == W) ? rdy_last : 1'b0, 1'b0);
        if (FRAME > W) tick(1'b1, pbit, rdy_last, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy_last);
        send_frame(w, ^w, rdy_last);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; en = 1'b0; si = 1'b0; data_ready = 1'b0;
        do_reset();

        send_word(8'hA5, 1'b0);
        check("tp_a5.dout", 32'(dout0), 32'h0000_00A5);
        check("tp_a5.valid", 32'(dv0), 32'd1);
        check("tp_a5.wc", 32'(wc0), 32'd1);

        do_reset();
        send_word(8'h1E, 1'b0);
        check("tp_order.lsb", 32'(dout0), 32'h0000_001E);
        check("tp_order.msb", 32'(dout1), 32'h0000_0078);

        do_reset();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        check("tp_ovr.dout", 32'(dout0), 32'h0000_0011);
        check("tp_ovr.flag", 32'(ov0), 32'd1);

        do_reset();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        check("tp_rdy.dout", 32'(dout0), 32'h0000_0022);
        check("tp_rdy.flag", 32'(ov0), 32'd0);
        check("tp_rdy.valid", 32'(dv0), 32'd1);

        do_reset();
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] g;
            g = 8'h5A;
            tick(1'b1, g[i], 1'b0, 1'b0);
            tick(1'b0, 1'($urandom), 1'b0, 1'b0);
        end
        if (FRAME > W) tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("tp_gap.dout", 32'(dout0), 32'h0000_005A);

        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'($urandom), 1'b0, 1'b0);
        do_reset();
        send_word(8'hC3, 1'b0);
        check("tp_rst.dout", 32'(dout0), 32'h0000_00C3);
        check("tp_rst.wc", 32'(wc0), 32'd1);

        do_reset();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("tp_clr.ovr", 32'(ov0), 32'd0);
        check("tp_clr.wc", 32'(wc0), 32'd2);
        send_word(8'h3C, 1'b0);
        check("tp_clr.dout", 32'(dout0), 32'h0000_003C);

`ifdef DESER_PARITY_EN
        do_reset();
        send_frame(8'h07, 1'b1, 1'b1);
        check("tp_par.ok", 32'(pe0), 32'd0);
        send_frame(8'h07, 1'b0, 1'b1);
        check("tp_par.bad", 32'(pe0), 32'd1);
`endif

        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
